// File: rtl/masked_sbox_bank.sv
// Time-multiplexed bank of masked AES S-boxes: a shared state is issued NUM_SBOX bytes per cycle
// through a three-stage masked GF(2^8) inverter framed by mode-selected affine layers.
module masked_sbox_bank #(
   parameter int unsigned NUM_SHARES  = 2,
   parameter int unsigned NUM_BYTES   = 16,
   parameter int unsigned NUM_SBOX    = 4,
   parameter int unsigned INV_LATENCY = 3,
   localparam int unsigned SW         = NUM_SHARES * 8,
   localparam int unsigned NUM_RANDOM = 4 * 8 * (NUM_SHARES * (NUM_SHARES - 1) / 2)
) (
   input  logic                           in_clock,
   input  logic                           in_reset,
   input  logic                           in_valid,
   output logic                           out_in_ready,
   input  logic                           in_enc,
   input  logic [NUM_BYTES*SW-1:0]        in_state,
   input  logic [NUM_SBOX*NUM_RANDOM-1:0] in_random,
   output logic                           out_valid,
   input  logic                           in_out_ready,
   output logic [NUM_BYTES*SW-1:0]        out_state
);

   localparam int unsigned NPAIR     = NUM_SHARES * (NUM_SHARES - 1) / 2;
   localparam int unsigned RW        = NPAIR * 8;
   localparam int unsigned NUM_BATCH = (NUM_BYTES + NUM_SBOX - 1) / NUM_SBOX;
   localparam int unsigned BW        = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Squaring is GF(2)-linear, so it is applied to each share independently.
   function automatic logic [SW-1:0] sh_sq(input logic [SW-1:0] a);
      logic [SW-1:0] r;
      for (int s = 0; s < NUM_SHARES; s++) r[s*8 +: 8] = gf_mul(a[s*8 +: 8], a[s*8 +: 8]);
      return r;
   endfunction

   function automatic logic [SW-1:0] sh_pow4(input logic [SW-1:0] a);
      return sh_sq(sh_sq(a));
   endfunction

   // ISW multiplication: one fresh byte per share pair.
   function automatic logic [SW-1:0] isw_mul(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic [RW-1:0] r);
      logic [SW-1:0] c;
      logic [7:0]    rij;
      logic [7:0]    rji;
      int unsigned   p;
      p = 0;
      for (int i = 0; i < NUM_SHARES; i++) c[i*8 +: 8] = gf_mul(a[i*8 +: 8], b[i*8 +: 8]);
      for (int i = 0; i < NUM_SHARES; i++) begin
         for (int j = i + 1; j < NUM_SHARES; j++) begin
            rij = r[p*8 +: 8];
            rji = (rij ^ gf_mul(a[i*8 +: 8], b[j*8 +: 8])) ^ gf_mul(a[j*8 +: 8], b[i*8 +: 8]);
            c[i*8 +: 8] = c[i*8 +: 8] ^ rij;
            c[j*8 +: 8] = c[j*8 +: 8] ^ rji;
            p = p + 1;
         end
      end
      return c;
   endfunction

   // Affine layer: linear part on every share, constant only on share 0.
   function automatic logic [SW-1:0] sh_affine(input logic [SW-1:0] a, input logic inv);
      logic [SW-1:0] r;
      logic [7:0]    b;
      for (int s = 0; s < NUM_SHARES; s++) begin
         b = a[s*8 +: 8];
         if (inv) r[s*8 +: 8] = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
         else     r[s*8 +: 8] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
      end
      r[7:0] = r[7:0] ^ (inv ? 8'h05 : 8'h63);
      return r;
   endfunction

   state_t                           state_q, state_d;
   logic [BW-1:0]                    batch_q, batch_d;
   logic                             mode_q, mode_d;
   logic [NUM_BYTES*SW-1:0]          in_state_q, in_state_d;
   logic                             out_valid_q, out_valid_d;
   logic [NUM_BYTES*SW-1:0]          out_state_q, out_state_d;
   logic                             last_wr_q, last_wr_d;
   logic [INV_LATENCY-1:0]           tag_v_q, tag_v_d;
   logic [INV_LATENCY-1:0][BW-1:0]   tag_b_q, tag_b_d;
   logic                             push_v;
   logic                             wr_v;
   logic [BW-1:0]                    wr_b;

   logic [NUM_SBOX-1:0][SW-1:0] lane_in, lane_out, x12, x15, x240;
   logic [NUM_SBOX-1:0][SW-1:0] s1_x2_q, s1_x2_d, s1_x3_q, s1_x3_d;
   logic [NUM_SBOX-1:0][SW-1:0] s2_x2_q, s2_x2_d, s2_x252_q, s2_x252_d;
   logic [NUM_SBOX-1:0][SW-1:0] s3_inv_q, s3_inv_d;

   assign out_in_ready = (state_q == S_IDLE) && !in_reset;
   assign out_valid    = out_valid_q;
   assign out_state    = out_state_q;
   assign wr_v         = tag_v_q[INV_LATENCY-1];
   assign wr_b         = tag_b_q[INV_LATENCY-1];

   // Front basis on the current batch; lanes past the last byte stay all-zero.
   always_comb begin : lane_issue
      lane_in = '0;
      for (int k = 0; k < NUM_SBOX; k++) begin
         if ((state_q == S_ISSUE) && (32'(batch_q) * NUM_SBOX + 32'(k) < NUM_BYTES)) begin
            lane_in[k] = in_state_q[(32'(batch_q) * NUM_SBOX + 32'(k)) * SW +: SW];
            if (!mode_q) lane_in[k] = sh_affine(lane_in[k], 1'b1);
         end
      end
   end

   // x^254 = ((x^3)^4 * x^3)^16 * (x^3)^4 * x^2, split over three register stages.
   always_comb begin : inv_pipe
      for (int k = 0; k < NUM_SBOX; k++) begin
         s1_x2_d[k]   = sh_sq(lane_in[k]);
         s1_x3_d[k]   = isw_mul(s1_x2_d[k], lane_in[k], in_random[k*NUM_RANDOM + 0*RW +: RW]);
         x12[k]       = sh_pow4(s1_x3_q[k]);
         x15[k]       = isw_mul(x12[k], s1_x3_q[k], in_random[k*NUM_RANDOM + 1*RW +: RW]);
         x240[k]      = sh_pow4(sh_pow4(x15[k]));
         s2_x252_d[k] = isw_mul(x240[k], x12[k], in_random[k*NUM_RANDOM + 2*RW +: RW]);
         s2_x2_d[k]   = s1_x2_q[k];
         s3_inv_d[k]  = isw_mul(s2_x252_q[k], s2_x2_q[k], in_random[k*NUM_RANDOM + 3*RW +: RW]);
         lane_out[k]  = mode_q ? sh_affine(s3_inv_q[k], 1'b0) : s3_inv_q[k];
      end
   end

   always_comb begin : tag_write
      tag_v_d[0] = push_v;
      tag_b_d[0] = batch_q;
      for (int i = 1; i < INV_LATENCY; i++) begin
         tag_v_d[i] = tag_v_q[i-1];
         tag_b_d[i] = tag_b_q[i-1];
      end
      out_state_d = out_state_q;
      if (wr_v) begin
         for (int k = 0; k < NUM_SBOX; k++) begin
            if (32'(wr_b) * NUM_SBOX + 32'(k) < NUM_BYTES)
               out_state_d[(32'(wr_b) * NUM_SBOX + 32'(k)) * SW +: SW] = lane_out[k];
         end
      end
      last_wr_d = wr_v && (wr_b == BW'(NUM_BATCH - 1));
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      batch_d     = batch_q;
      mode_d      = mode_q;
      in_state_d  = in_state_q;
      out_valid_d = out_valid_q;
      push_v      = 1'b0;
      unique case (state_q)
         S_IDLE: if (in_valid) begin
            state_d    = S_ISSUE;
            batch_d    = '0;
            mode_d     = in_enc;
            in_state_d = in_state;
         end
         S_ISSUE: begin
            push_v = 1'b1;
            if (batch_q == BW'(NUM_BATCH - 1)) state_d = S_DRAIN;
            else                               batch_d = batch_q + BW'(1);
         end
         S_DRAIN: if (last_wr_q) begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: if (in_out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clock or posedge in_reset) begin : regs
      if (in_reset) begin
         state_q     <= S_IDLE;
         batch_q     <= '0;
         mode_q      <= 1'b0;
         in_state_q  <= '0;
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         last_wr_q   <= 1'b0;
         tag_v_q     <= '0;
         tag_b_q     <= '0;
         s1_x2_q     <= '0;
         s1_x3_q     <= '0;
         s2_x2_q     <= '0;
         s2_x252_q   <= '0;
         s3_inv_q    <= '0;
      end else begin
         state_q     <= state_d;
         batch_q     <= batch_d;
         mode_q      <= mode_d;
         in_state_q  <= in_state_d;
         out_valid_q <= out_valid_d;
         out_state_q <= out_state_d;
         last_wr_q   <= last_wr_d;
         tag_v_q     <= tag_v_d;
         tag_b_q     <= tag_b_d;
         s1_x2_q     <= s1_x2_d;
         s1_x3_q     <= s1_x3_d;
         s2_x2_q     <= s2_x2_d;
         s2_x252_q   <= s2_x252_d;
         s3_inv_q    <= s3_inv_d;
      end
   end

endmodule

// File: tb/tb_masked_sbox_bank.sv
// Directed bench for masked_sbox_bank: default bank plus a 3-share / 3-lane bank with a partial batch,
// checked against an S-box model built from GF(2^8) log tables and the bitwise affine map.
module tb_masked_sbox_bank;
   localparam int unsigned NB = 16;
   localparam int unsigned SA = 2;
   localparam int unsigned LA = 4;
   localparam int unsigned RA = 32;
   localparam int unsigned SB = 3;
   localparam int unsigned LB = 3;
   localparam int unsigned RB = 96;

   logic                 in_clock, in_reset;
   logic                 in_valid_a, out_in_ready_a, in_enc_a, out_valid_a, in_out_ready_a;
   logic [NB*SA*8-1:0]   in_state_a, out_state_a;
   logic [LA*RA-1:0]     in_random_a;
   logic                 in_valid_b, out_in_ready_b, in_enc_b, out_valid_b, in_out_ready_b;
   logic [NB*SB*8-1:0]   in_state_b, out_state_b;
   logic [LB*RB-1:0]     in_random_b;

   logic [7:0] sbox [256];
   logic [7:0] isbox [256];
   logic [7:0] pt [NB];
   logic [7:0] orig [NB];
   logic [7:0] exp_a [NB];
   logic [7:0] exp_b [NB];
   int n_cmp, n_fail;

   masked_sbox_bank u_dut_a (
      .in_clock(in_clock), .in_reset(in_reset), .in_valid(in_valid_a), .out_in_ready(out_in_ready_a),
      .in_enc(in_enc_a), .in_state(in_state_a), .in_random(in_random_a), .out_valid(out_valid_a),
      .in_out_ready(in_out_ready_a), .out_state(out_state_a));

   masked_sbox_bank #(.NUM_SHARES(SB), .NUM_BYTES(NB), .NUM_SBOX(LB), .INV_LATENCY(3)) u_dut_b (
      .in_clock(in_clock), .in_reset(in_reset), .in_valid(in_valid_b), .out_in_ready(out_in_ready_b),
      .in_enc(in_enc_b), .in_state(in_state_b), .in_random(in_random_b), .out_valid(out_valid_b),
      .in_out_ready(in_out_ready_b), .out_state(out_state_b));

   initial begin
      in_clock = 1'b0;
      forever #5 in_clock = ~in_clock;
   end

   function automatic logic [7:0] xtime(input logic [7:0] e);
      return {e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00);
   endfunction

   // FIPS-197 affine map written bit by bit.
   function automatic logic [7:0] aff(input logic [7:0] b);
      logic [7:0] c;
      logic [7:0] r;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      return r;
   endfunction

   task automatic build_model();
      logic [7:0] alog [256];
      int         lg [256];
      logic [7:0] e;
      logic [7:0] inv;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         alog[i]  = e;
         lg[int'(e)] = i;
         e = e ^ xtime(e);
      end
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
         sbox[x] = aff(inv);
      end
      for (int x = 0; x < 256; x++) isbox[int'(sbox[x])] = 8'(x);
   endtask

   function automatic logic [7:0] um_a(input logic [NB*SA*8-1:0] st, input int b);
      return st[b*16 +: 8] ^ st[b*16+8 +: 8];
   endfunction

   function automatic logic [7:0] um_b(input logic [NB*SB*8-1:0] st, input int b);
      return st[b*24 +: 8] ^ st[b*24+8 +: 8] ^ st[b*24+16 +: 8];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   // One clock: compare any presented result against the model at negedge, then refresh randomness.
   task automatic step();
      logic bad;
      @(negedge in_clock);
      if (!in_reset && out_valid_a) begin
         bad = 1'b0;
         for (int b = 0; b < NB; b++)
            if (um_a(out_state_a, b) !== exp_a[b]) begin
               if (!bad) $display("FAIL sb_a byte %0d: got %0h expected %0h", b, um_a(out_state_a, b), exp_a[b]);
               bad = 1'b1;
            end
         n_cmp++;
         if (bad) n_fail++;
      end
      if (!in_reset && out_valid_b) begin
         bad = 1'b0;
         for (int b = 0; b < NB; b++)
            if (um_b(out_state_b, b) !== exp_b[b]) begin
               if (!bad) $display("FAIL sb_b byte %0d: got %0h expected %0h", b, um_b(out_state_b, b), exp_b[b]);
               bad = 1'b1;
            end
         n_cmp++;
         if (bad) n_fail++;
      end
      @(posedge in_clock);
      #1;
      for (int w = 0; w < LA*RA/32; w++) in_random_a[w*32 +: 32] = $urandom;
      for (int w = 0; w < LB*RB/32; w++) in_random_b[w*32 +: 32] = $urandom;
   endtask

   task automatic issue_a(input logic enc);
      logic [7:0] m;
      for (int i = 0; i < NB; i++) begin
         m = 8'($urandom);
         in_state_a[i*16 +: 8]   = m;
         in_state_a[i*16+8 +: 8] = pt[i] ^ m;
         exp_a[i] = enc ? sbox[int'(pt[i])] : isbox[int'(pt[i])];
      end
      in_enc_a   = enc;
      in_valid_a = 1'b1;
   endtask

   task automatic issue_b(input logic enc);
      logic [7:0] m0, m1;
      for (int i = 0; i < NB; i++) begin
         m0 = 8'($urandom);
         m1 = 8'($urandom);
         in_state_b[i*24 +: 8]    = m0;
         in_state_b[i*24+8 +: 8]  = m1;
         in_state_b[i*24+16 +: 8] = pt[i] ^ m0 ^ m1;
         exp_b[i] = enc ? sbox[int'(pt[i])] : isbox[int'(pt[i])];
      end
      in_enc_b   = enc;
      in_valid_b = 1'b1;
   endtask

   task automatic accept_a(output int w);
      w = 0;
      while (!out_in_ready_a && w < 30) begin step(); w++; end
      if (!out_in_ready_a) chk("accept_a_timeout", 32'(out_in_ready_a), 32'd1);
      step();
      in_valid_a = 1'b0;
   endtask

   task automatic done_a(input logic flip, output int lat);
      lat = 0;
      while (!out_valid_a && lat < 40) begin
         step();
         lat++;
         if (flip) in_enc_a = ~in_enc_a;
      end
   endtask

   task automatic take_a();
      in_out_ready_a = 1'b1;
      step();
      in_out_ready_a = 1'b0;
   endtask

   task automatic op_b(input logic enc, input string nm);
      int w, lat;
      issue_b(enc);
      w = 0;
      while (!out_in_ready_b && w < 30) begin step(); w++; end
      step();
      in_valid_b = 1'b0;
      lat = 0;
      while (!out_valid_b && lat < 40) begin step(); lat++; end
      chk(nm, 32'(lat), 32'd10);
      in_out_ready_b = 1'b1;
      step();
      in_out_ready_b = 1'b0;
   endtask

   initial begin
      int w, lat;
      logic ok;
      logic [NB*SA*8-1:0] snap;
      n_cmp = 0; n_fail = 0;
      in_reset = 1'b1;
      in_valid_a = 0; in_enc_a = 0; in_state_a = '0; in_random_a = '0; in_out_ready_a = 0;
      in_valid_b = 0; in_enc_b = 0; in_state_b = '0; in_random_b = '0; in_out_ready_b = 0;
      build_model();
      chk("model_sbox00", 32'(sbox[0]), 32'h63);
      chk("model_sbox01", 32'(sbox[1]), 32'h7C);
      chk("model_sbox0f", 32'(sbox[15]), 32'h76);
      chk("model_isbox63", 32'(isbox[8'h63]), 32'h00);
      chk("model_isbox00", 32'(isbox[0]), 32'h52);

      repeat (3) step();
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_out_state_zero", 32'(out_state_a == '0), 32'd1);
      chk("rst_in_ready_low", 32'(out_in_ready_a), 32'd0);
      in_reset = 1'b0;
      step();
      chk("idle_in_ready", 32'(out_in_ready_a), 32'd1);

      for (int i = 0; i < NB; i++) pt[i] = 8'(i);
      issue_a(1'b1); accept_a(w); done_a(1'b0, lat);
      chk("fwd_latency", 32'(lat), 32'd8);
      chk("fwd_byte0", 32'(um_a(out_state_a, 0)), 32'h63);
      chk("fwd_byte1", 32'(um_a(out_state_a, 1)), 32'h7C);
      chk("fwd_byte15", 32'(um_a(out_state_a, 15)), 32'h76);
      take_a();

      for (int i = 0; i < NB; i++) pt[i] = 8'h63;
      issue_a(1'b0); accept_a(w); done_a(1'b0, lat);
      chk("inv63_byte0", 32'(um_a(out_state_a, 0)), 32'h00);
      chk("inv63_byte9", 32'(um_a(out_state_a, 9)), 32'h00);
      take_a();
      for (int i = 0; i < NB; i++) pt[i] = 8'h00;
      issue_a(1'b0); accept_a(w); done_a(1'b0, lat);
      chk("inv00_byte0", 32'(um_a(out_state_a, 0)), 32'h52);
      chk("inv00_byte15", 32'(um_a(out_state_a, 15)), 32'h52);
      take_a();

      for (int i = 0; i < NB; i++) begin orig[i] = 8'($urandom); pt[i] = orig[i]; end
      issue_a(1'b1); accept_a(w); done_a(1'b0, lat); take_a();
      for (int i = 0; i < NB; i++) pt[i] = sbox[int'(orig[i])];
      issue_a(1'b0); accept_a(w); done_a(1'b0, lat);
      ok = 1'b1;
      for (int i = 0; i < NB; i++) if (um_a(out_state_a, i) !== orig[i]) ok = 1'b0;
      chk("round_trip", 32'(ok), 32'd1);
      take_a();

      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      issue_a(1'b1); accept_a(w); done_a(1'b1, lat);
      chk("mode_flip_latency", 32'(lat), 32'd8);
      take_a();
      in_enc_a = 1'b1;

      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      issue_a(1'b1); accept_a(w); done_a(1'b0, lat);
      snap = out_state_a;
      in_valid_a = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         step();
         if (!(out_valid_a && out_state_a == snap && !out_in_ready_a)) ok = 1'b0;
      end
      chk("bp_hold", 32'(ok), 32'd1);
      in_valid_a = 1'b0;
      take_a();
      chk("bp_idle_gap", 32'({out_in_ready_a, out_valid_a}), 32'b10);
      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      issue_a(1'b1); accept_a(w);
      chk("bp_accept_wait", 32'(w), 32'd0);
      done_a(1'b0, lat);
      chk("bp_next_latency", 32'(lat), 32'd8);
      take_a();

      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      issue_a(1'b1); accept_a(w);
      repeat (5) step();
      in_reset = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
      chk("midrst_out_state_zero", 32'(out_state_a == '0), 32'd1);
      chk("midrst_in_ready", 32'(out_in_ready_a), 32'd0);
      step(); step();
      in_reset = 1'b0;
      step();
      for (int i = 0; i < NB; i++) pt[i] = 8'((i * 37 + 5) & 255);
      issue_a(1'b1); accept_a(w); done_a(1'b0, lat);
      chk("postrst_latency", 32'(lat), 32'd8);
      take_a();

      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      op_b(1'b1, "b_fwd_latency");
      for (int i = 0; i < NB; i++) pt[i] = 8'($urandom);
      op_b(1'b0, "b_inv_latency");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
